// File: rtl/pipe_if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry circular FIFO of (pc, inst) pairs feeding a
// registered output stage to ID, with single-cycle flush and a bypass path when empty.
module pipe_if_id_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         discard,
  input  logic                         push_valid,
  input  logic [ADDR_WIDTH-1:0]        push_pc,
  input  logic [INST_WIDTH-1:0]        push_inst,
  output logic                         full,
  input  logic                         id_stall,
  output logic                         valid_o,
  output logic [ADDR_WIDTH-1:0]        pc_o,
  output logic [INST_WIDTH-1:0]        inst_o,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: IF offers (push_pc, push_inst) with push_valid; the offer is taken
  // only when full is low at that edge, otherwise it is lost and IF must re-present it.
  // ID consumes the output stage on every edge where id_stall is low.

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;

  logic push_acc;
  logic pop;
  logic bypass;
  logic enq;

  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    push_acc = push_valid && !full;
    pop      = 1'b0;
    bypass   = 1'b0;
    enq      = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    inst_d   = inst_q;

    if (reset || discard) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      pc_d     = '0;
      inst_d   = '0;
    end else begin
      pop    = !id_stall && (count_q != '0);
      bypass = !id_stall && (count_q == '0) && push_acc;
      enq    = push_acc && !bypass;

      if (!id_stall) begin
        if (pop) begin
          valid_d = 1'b1;
          pc_d    = pc_mem_q[rd_ptr_q];
          inst_d  = inst_mem_q[rd_ptr_q];
        end else if (bypass) begin
          valid_d = 1'b1;
          pc_d    = push_pc;
          inst_d  = push_inst;
        end else begin
          valid_d = 1'b0;
          pc_d    = '0;
          inst_d  = '0;
        end
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      inst_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
    end
  end

  // Entry storage is never reset; only slots between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]   <= push_pc;
      inst_mem_q[wr_ptr_q] <= push_inst;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign count   = count_q;

endmodule

// File: tb/tb_pipe_if_id_queue.sv
// Bench for pipe_if_id_queue: directed test-plan scenarios plus randomized traffic,
// all compared against a queue-based reference model of the IF/ID queue.
module tb_pipe_if_id_queue;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int W     = AW + IW;

  logic          clock = 1'b0;
  logic          reset;
  logic          discard;
  logic          push_valid;
  logic [AW-1:0] push_pc;
  logic [IW-1:0] push_inst;
  logic          full;
  logic          id_stall;
  logic          valid_o;
  logic [AW-1:0] pc_o;
  logic [IW-1:0] inst_o;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending entries plus the output stage.
  logic [W-1:0]  exp_q[$];
  logic          m_valid;
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_inst;

  pipe_if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .discard(discard),
    .push_valid(push_valid), .push_pc(push_pc), .push_inst(push_inst),
    .full(full), .id_stall(id_stall),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic disc, input logic pv,
                            input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                            input logic stall);
    logic acc;
    if (rst || disc) begin
      exp_q.delete();
      m_valid = 1'b0; m_pc = '0; m_inst = '0;
    end else begin
      acc = pv && (exp_q.size() < DEPTH);
      if (!stall) begin
        if (exp_q.size() > 0) begin
          {m_pc, m_inst} = exp_q.pop_front();
          m_valid = 1'b1;
          if (acc) exp_q.push_back({pc, inst});
        end else if (acc) begin
          m_pc = pc; m_inst = inst; m_valid = 1'b1;
        end else begin
          m_pc = '0; m_inst = '0; m_valid = 1'b0;
        end
      end else if (acc) begin
        exp_q.push_back({pc, inst});
      end
    end
  endtask

  // One clock: drive inputs, check full before the edge, advance model, check after.
  task automatic step(input logic rst, input logic disc, input logic pv,
                      input logic [AW-1:0] pc, input logic stall);
    logic [IW-1:0] inst;
    inst = $urandom() | 32'h1;
    reset = rst; discard = disc; push_valid = pv; push_pc = pc;
    push_inst = inst; id_stall = stall;
    #1;
    check("full_pre", full, exp_q.size() == DEPTH);
    @(posedge clock);
    model_edge(rst, disc, pv, pc, inst, stall);
    #1;
    check("count", count, exp_q.size());
    check("full", full, exp_q.size() == DEPTH);
    check("valid_o", valid_o, m_valid);
    check("pc_o", pc_o, m_pc);
    check("inst_o", inst_o, m_inst);
  endtask

  initial begin
    reset = 1'b1; discard = 1'b0; push_valid = 1'b0; push_pc = '0;
    push_inst = '0; id_stall = 1'b0;
    exp_q.delete();
    m_valid = 1'b0; m_pc = '0; m_inst = '0;
    @(posedge clock); #1;

    step(1, 0, 0, 0, 0);
    check("rst_valid", valid_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);

    // Bypass flow
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'(i * 4), 0);
      check("byp_pc", pc_o, 64'(i * 4));
      check("byp_valid", valid_o, 1);
      check("byp_count", count, 0);
    end
    step(0, 0, 0, 0, 0);
    check("byp_bubble", valid_o, 0);

    // Stall and fill: fifth push must be dropped
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 32'h10 + 32'(i * 4), 1);
      check("fill_count", count, (i < 4) ? 64'(i + 1) : 64'd4);
    end
    check("fill_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      check("drain_pc", pc_o, 64'h10 + 64'(i * 4));
    end
    step(0, 0, 0, 0, 0);
    check("drain_bubble", valid_o, 0);

    // Full with simultaneous pop and push
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h30 + 32'(i * 4), 1);
    step(0, 0, 1, 32'h40, 0);
    check("fpp_pc", pc_o, 64'h30);
    check("fpp_count", count, 3);
    check("fpp_full", full, 0);

    // Discard with concurrent push
    step(0, 1, 1, 32'h80, 0);
    check("dis_count", count, 0);
    check("dis_valid", valid_o, 0);
    check("dis_inst", inst_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("dis_no80", valid_o, 0);
    end

    // Randomized traffic with wrap-around and occasional flush
    begin
      logic [AW-1:0] next_pc;
      logic          pv;
      next_pc = 32'h1000;
      for (int i = 0; i < 300; i++) begin
        pv = ($urandom_range(0, 3) != 0);
        step(0, ($urandom_range(0, 60) == 0), pv, next_pc,
             ($urandom_range(0, 2) == 0));
        if (pv) next_pc = next_pc + 32'd4;
      end
    end

    // Mid-stall reset with the queue full
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h200 + 32'(i * 4), 1);
    check("pre_rst_full", full, 1);
    step(1, 0, 1, 32'h300, 1);
    check("mrst_valid", valid_o, 0);
    check("mrst_pc", pc_o, 0);
    check("mrst_inst", inst_o, 0);
    check("mrst_count", count, 0);
    check("mrst_full", full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_if_id_queue.md
# pipe_if_id_queue

Parametrised successor to the single-entry IF/ID pipeline register. It decouples instruction fetch from decode with a DEPTH-entry FIFO of (pc, inst) pairs plus a registered output stage feeding ID. Fetch keeps running while ID stalls, until the queue fills. The block has single-cycle flush (discard), emits zero bubbles when empty, and reports back-pressure to IF through `full`.

## Interface
- `ADDR_WIDTH`, default 32: width of the pc field.
- `INST_WIDTH`, default 32: width of the instruction field.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and ≥ 2.
- `clock  in  1`: single clock; all state updates on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `discard  in  1`: synchronous flush on branch mispredict or jump. Clears the FIFO and the output stage.
- `push_valid  in  1`: IF presents a fetched instruction this cycle.
- `push_pc  in  ADDR_WIDTH`: pc of the pushed instruction.
- `push_inst  in  INST_WIDTH`: pushed instruction word.
- `full  out  1`: combinational, equals `count == DEPTH`. IF must stall its pc while `full` is high.
- `id_stall  in  1`: ID is not consuming this cycle, so the output stage holds.
- `valid_o  out  1`: output stage holds a real instruction; 0 means bubble.
- `pc_o  out  ADDR_WIDTH`: pc presented to ID.
- `inst_o  out  INST_WIDTH`: instruction presented to ID. It is 0 (bubble) whenever `valid_o` is 0.
- `count  out  $clog2(DEPTH+1)`: current FIFO occupancy. The output stage is not included.

## Operation
- **Storage**
  - Circular buffer of DEPTH entries.
  - Read pointer and write pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy held in `count`.
- **Push**
  - A push is accepted when `push_valid && !full`.
  - When full, the push is dropped even if a pop happens in the same cycle. IF is already seeing `full` and must re-present the instruction.
- **Pop / output load**, evaluated each edge when not reset, not discard, and `id_stall` is 0:
  - If `count > 0`: head entry goes to the output stage, `valid_o` becomes 1, read pointer advances.
  - Else if a push is accepted this cycle: the push bypasses the FIFO into the output stage, `valid_o` becomes 1, and `count` is unchanged.
  - Else: output stage loads bubble (`pc_o` = 0, `inst_o` = 0, `valid_o` = 0).
- **Stall**
  - When `id_stall` is 1, `pc_o`, `inst_o` and `valid_o` hold.
  - Accepted pushes still enqueue.
- **Count update**
  - `count` next = `count` + (push enqueued) − (pop from FIFO).
  - A bypass push counts as neither an enqueue nor a pop.
- **Priority**: reset > discard > normal operation.
  - On reset or discard: both pointers go to 0, `count` to 0, and the output stage to bubble.
  - Any push in the same cycle is dropped.
- **Storage contents**: entry RAM contents need no reset; unread entries are never observable.

## Timing
- **Reset values**: `pc_o` = 0, `inst_o` = 0, `valid_o` = 0, `count` = 0, `full` = 0.
- **Latency**: a push into an empty queue with `id_stall` low appears on the outputs the cycle after the push edge. This is 1 cycle, identical to a plain pipeline register.
- **Queued entries**: one entry leaves per non-stalled cycle, in strict FIFO order.
- **Back-to-back flow**: when `count` = 0 and `id_stall` = 0, sustains 1 instruction per cycle with no bubbles.
- **Back-pressure**: `full` rises in the cycle after the DEPTH-th enqueue. It falls in the cycle after the first pop from a full queue.
- **Wrap-around**: pointers wrap from DEPTH−1 to 0 without any gap or duplicate entry.
- **Flush timing**: `discard` takes effect at the edge where it is sampled high. In the next cycle `valid_o` = 0 and `count` = 0. The first post-flush push can appear on the outputs one cycle after that.
- **Reset mid-operation**: identical to discard. No partial state survives.

## Test plan
- **Bypass flow**
  - Stimulus: reset, then push pc 0x00, 0x04, 0x08 on consecutive cycles with `id_stall` = 0.
  - Required: outputs show 0x00, 0x04, 0x08 on cycles 1, 2, 3; `count` stays 0 throughout.
- **Stall and fill**
  - Stimulus: hold `id_stall` = 1 while pushing 5 instructions, with DEPTH = 4.
  - Required: `count` goes 1→4, `full` = 1 after the 4th push, and the 5th push is dropped.
  - Stimulus: release the stall.
  - Required: outputs 4 queued pcs in order over 4 cycles, then a bubble.
- **Full with simultaneous pop and push**
  - Stimulus: queue full, `id_stall` = 0, push pc 0x40.
  - Required: head is popped, 0x40 is dropped, `count` = 3, `full` = 0 next cycle.
- **Discard with concurrent push**
  - Stimulus: `count` = 3 and `discard` = 1 together with push pc 0x80.
  - Required next cycle: `count` = 0, `valid_o` = 0, `inst_o` = 0, and 0x80 never appears.
- **Wrap-around**
  - Stimulus: 3 × DEPTH pushes interleaved with random `id_stall`.
  - Required: output pc sequence equals the accepted push sequence exactly, checked against a scoreboard.
- **Mid-stall reset**
  - Stimulus: assert `reset` while the queue is full and `id_stall` = 1.
  - Required: all outputs at reset values the next cycle; `full` = 0.
